// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment display sharing logic.
// Holds the arbiter FSM encoding and the hex-to-segment pattern table.
package seg_pkg;

    localparam int REQ_N = 2;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Segment patterns {g,f,e,d,c,b,a} for hex digits 0..F.
    localparam logic [6:0] HEX7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg_share_arbiter_if.sv
// Requester-side bundle of the shared display: requests, data and the
// grant/done/busy/SEG responses. Master drives requests, slave is the arbiter.
interface seg_share_arbiter_if;

    logic [seg_pkg::REQ_N-1:0] req;
    logic [3:0]                data0;
    logic [3:0]                data1;
    logic [seg_pkg::REQ_N-1:0] gnt;
    logic [seg_pkg::REQ_N-1:0] done;
    logic                      busy;
    logic [7:0]                SEG;

    modport master (
        output req, data0, data1,
        input  gnt, done, busy, SEG
    );

    modport slave (
        input  req, data0, data1,
        output gnt, done, busy, SEG
    );

endinterface

// File: rtl/hex7seg.sv
// Combinational hex digit to 7-segment pattern lookup, zero latency.
// No handshake; output follows the input directly.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] val_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX7[val_i];

endmodule

// File: rtl/seg_share_arbiter.sv
// Round-robin sharing of one 7-segment display between two requesters.
// Grant on the edge after a request is seen in IDLE; HOLD show cycles then GAP blank cycles; requests wait while busy.
module seg_share_arbiter
    import seg_pkg::*;
#(
    parameter int HOLD = 4,
    parameter int GAP  = 1
)(
    input  logic              clk_2,
    input  logic              reset,
    seg_share_arbiter_if.slave sb
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [3:0] val_q,   val_d;
    logic       cur_q,   cur_d;
    logic       last_q,  last_d;

    logic       win;
    logic [6:0] seg7;

    logic [REQ_N-1:0] gnt;
    logic [REQ_N-1:0] done;
    logic             busy;
    logic [7:0]       seg;

    hex7seg u_hex7seg (
        .val_i (val_q),
        .seg_o (seg7)
    );

    // On a tie the requester that was not served last wins.
    always_comb begin
        win = 1'b0;
        case (sb.req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_q;
            default: win = 1'b0;
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            val_q   <= 4'd0;
            cur_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        cur_d   = cur_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|sb.req) begin
                    state_d = SHOW;
                    cur_d   = win;
                    val_d   = win ? sb.data1 : sb.data0;
                    cnt_d   = HOLD_LOAD;
                end
            end
            SHOW: begin
                if (cnt_q == 8'd0) begin
                    last_d = cur_q;
                    if (GAP == 0) begin
                        state_d = IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = seg_pkg::GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            seg_pkg::GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Outputs depend on registered state only, so no input reaches them combinationally.
    always_comb begin
        gnt  = '0;
        done = '0;
        busy = 1'b0;
        seg  = SEG_BLANK;
        case (state_q)
            SHOW: begin
                gnt[cur_q]  = 1'b1;
                done[cur_q] = (cnt_q == 8'd0);
                busy        = 1'b1;
                seg         = {cur_q, seg7};
            end
            seg_pkg::GAP: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign sb.gnt  = gnt;
    assign sb.done = done;
    assign sb.busy = busy;
    assign sb.SEG  = seg;

endmodule

// File: tb/tb_seg_share_arbiter.sv
// Directed stimulus for the shared display arbiter; expected busy-cycle
// outputs are queued up front and a negedge monitor compares them in order.
module tb_seg_share_arbiter;

    localparam int HOLD = 4;
    localparam int GAP  = 1;

    typedef struct packed {
        logic [1:0] gnt;
        logic [1:0] done;
        logic [7:0] seg;
    } exp_t;

    logic clk_2 = 1'b0;
    logic reset = 1'b1;
    bit   mon_en = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    logic [6:0] hex [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    always #5 clk_2 = ~clk_2;

    seg_share_arbiter_if sb ();

    seg_share_arbiter #(.HOLD(HOLD), .GAP(GAP)) dut (
        .clk_2 (clk_2),
        .reset (reset),
        .sb    (sb)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_2);
        #1;
    endtask

    task automatic push_show(input int r, input int v, input int cycles, input bit with_done);
        exp_t e;
        for (int i = 0; i < cycles; i++) begin
            e.gnt  = 2'b01 << r;
            e.done = (with_done && i == cycles - 1) ? (2'b01 << r) : 2'b00;
            e.seg  = {r[0], hex[v]};
            exp_q.push_back(e);
        end
    endtask

    task automatic push_grant(input int r, input int v);
        exp_t e;
        push_show(r, v, HOLD, 1'b1);
        e = '0;
        for (int i = 0; i < GAP; i++) exp_q.push_back(e);
    endtask

    always @(negedge clk_2) begin
        exp_t e;
        if (mon_en) begin
            if (sb.busy === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_busy at %0t: gnt %b done %b SEG %h, nothing queued",
                             $time, sb.gnt, sb.done, sb.SEG);
                end else begin
                    e = exp_q.pop_front();
                    chk("busy_gnt",  {6'd0, sb.gnt},  {6'd0, e.gnt});
                    chk("busy_done", {6'd0, sb.done}, {6'd0, e.done});
                    chk("busy_seg",  sb.SEG, e.seg);
                end
            end else begin
                chk("idle_busy", {7'd0, sb.busy}, 8'd0);
                chk("idle_gnt",  {6'd0, sb.gnt},  8'd0);
                chk("idle_done", {6'd0, sb.done}, 8'd0);
                chk("idle_seg",  sb.SEG, 8'h00);
            end
        end
    end

    initial begin
        // Reset held two edges with both requests high: nothing may be granted.
        sb.req   = 2'b11;
        sb.data0 = 4'h0;
        sb.data1 = 4'h0;
        reset    = 1'b1;
        tick(1);
        mon_en = 1'b1;
        tick(1);
        chk("reset_busy", {7'd0, sb.busy}, 8'd0);
        chk("reset_seg",  sb.SEG, 8'h00);
        sb.req = 2'b00;
        reset  = 1'b0;
        tick(2);

        // Single request from requester 0 with value A.
        push_grant(0, 4'hA);
        sb.req   = 2'b01;
        sb.data0 = 4'hA;
        tick(5);
        sb.req = 2'b00;
        tick(3);

        // Tie right after reset: requester 0 first, then requester 1.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        push_grant(0, 4'h0);
        push_grant(1, 4'h3);
        sb.req   = 2'b11;
        sb.data0 = 4'h0;
        sb.data1 = 4'h3;
        tick(5);
        sb.req = 2'b10;
        tick(6);
        sb.req = 2'b00;
        tick(3);

        // Continuous two-sided demand for 30 cycles: five alternating grants.
        sb.data0 = 4'h1;
        sb.data1 = 4'h2;
        for (int g = 0; g < 5; g++) push_grant(g % 2, (g % 2) ? 2 : 1);
        sb.req = 2'b11;
        tick(30);
        sb.req = 2'b00;
        tick(6);

        // Data change during SHOW must not reach the display.
        push_grant(1, 4'h5);
        sb.req   = 2'b10;
        sb.data1 = 4'h5;
        tick(2);
        sb.data1 = 4'hE;
        tick(3);
        sb.req = 2'b00;
        tick(3);

        // Reset in the second SHOW cycle abandons the grant without done.
        push_show(1, 4'h7, 2, 1'b0);
        sb.req   = 2'b10;
        sb.data1 = 4'h7;
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        push_grant(1, 4'h7);
        tick(5);
        sb.req = 2'b00;
        tick(4);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expected: %0d queued responses never seen, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg_share_arbiter.md
# seg_share_arbiter

Round-robin arbiter that shares the board's single 7-segment display (SEG) between two requesters, for example the switch-latch path and a counter path. Each requester raises `req` with a 4-bit hex value. The arbiter grants one requester at a time, latches its value, and shows it for a fixed number of `clk_2` cycles. It then signals completion and inserts a blank gap before serving the next request. The block sits between the requester logic in `top` and the SEG output pins.

## Interface
- `HOLD`, default 4: display cycles per grant; legal range 1..255.
- `GAP`, default 1: blank cycles after each grant; legal range 0..255.
- `clk_2`  in  1  board clock (divided reference clock).
- `reset`  in  1  reset, synchronous, active-high; clock clk_2.
- `req`  in  2  request per requester; held high until its `done` pulse.
- `data0`  in  4  hex value of requester 0; sampled only at grant.
- `data1`  in  4  hex value of requester 1; sampled only at grant.
- `gnt`  out  2  one-hot grant; high for the whole SHOW phase.
- `done`  out  2  one-cycle pulse to the served requester in its final SHOW cycle.
- `busy`  out  1  high in SHOW and GAP.
- `SEG`  out  8  segments {dp,g,f,e,d,c,b,a}; dp = id of the served requester.

## Operation
- States: IDLE, SHOW, GAP. All outputs are decoded from registered state only (Moore outputs).
- IDLE:
  - SEG = 8'h00, gnt = 0, busy = 0.
  - If any `req` bit is high, select a winner and move to SHOW.
  - Winner selection: if only one requester is high, it wins. If both are high, the requester not equal to `last` wins.
  - On the same edge: latch the winner's data into `val`, latch the winner's index into `cur`, and set `cnt` = HOLD-1.
- SHOW:
  - gnt[cur] = 1, busy = 1, SEG = {cur, hex7(val)}.
  - `cnt` decrements each cycle.
  - When `cnt` == 0: done[cur] = 1 for that cycle and `last` <= `cur`.
  - Next state is GAP with `cnt` = GAP-1, or IDLE if GAP == 0.
- GAP:
  - SEG = 0, gnt = 0, busy = 1.
  - When `cnt` == 0, go to IDLE.
- hex7 encoding for 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Changes on `data0`/`data1` during SHOW are ignored, because `val` is already latched.
- Dropping `req` during SHOW does not abort the display; the full HOLD period and the `done` pulse still occur.
- A `req` still high when the arbiter returns to IDLE counts as a new request.
- Reset (synchronous): state = IDLE, `cnt` = 0, `val` = 0, `cur` = 0, `last` = 1 (so requester 0 wins the first tie). All outputs are 0 in the cycle after the reset edge.
- Reset during SHOW or GAP abandons the grant and produces no `done` pulse.
- `reset` has priority over every other transition.

## Timing
- A request is seen high at clock edge n while the arbiter is in IDLE.
- Edges n .. n+HOLD-1: the arbiter is in SHOW. `gnt` and SEG are valid in the cycles after these edges, i.e. exactly HOLD cycles.
- `done` is high in the cycle after edge n+HOLD-1, which is the final SHOW cycle.
- The requester drops `req` at edge n+HOLD.
- Edges n+HOLD .. n+HOLD+GAP-1: GAP (blank display).
- Edge n+HOLD+GAP: return to IDLE. The next grant happens at the earliest on edge n+HOLD+GAP+1.
- Grant period: HOLD+GAP+1 cycles. Under continuous two-sided demand, grants strictly alternate 0,1,0,1.
- There is no combinational path from inputs to outputs.

## Structure
- Package `seg_pkg`:
  - `state_t` enum {IDLE, SHOW, GAP};
  - `SEG_BLANK` = 8'h00;
  - `HEX7` constant array[16] of 7-bit patterns;
  - `REQ_N` = 2.
- Sub-module `hex7seg`: combinational 4-bit to 7-bit lookup using `HEX7`. It is shared with other display blocks in `top`.
- The arbiter holds the FSM, counter, `val`, `cur` and `last` registers.

## Test plan
- Reset: hold `reset` for 2 cycles with `req` = 2'b11 → `gnt`, `done`, `busy` and SEG are all 0, and the state remains IDLE.
- Single request (HOLD=4, GAP=1): `req` = 01, `data0` = 4'hA → `gnt` = 01 and SEG = 8'h77 for 4 cycles; `done` = 01 in the 4th cycle; SEG = 00 with `busy` = 1 for 1 cycle; then IDLE.
- Tie after reset: `req` = 11, `data0` = 4'h0, `data1` = 4'h3 → first SEG = 8'h3F with `gnt` = 01; after the gap, SEG = 8'hCF with `gnt` = 10.
- Fairness: `req` = 11 held for 30 cycles → the grant sequence is 01,10,01,10,…; each `done` pulse is 1 cycle wide and `done` bits are never both high.
- Data stability: `req` = 10, `data1` = 4'h5, then `data1` changed to 4'hE in the 2nd SHOW cycle → SEG stays 8'hED for all 4 cycles.
- Reset mid-SHOW: assert `reset` in the 2nd SHOW cycle → outputs go to 0 on the next edge with no `done` pulse; after release with `req` = 10, requester 1 is granted (since `last` = 1 → wait: after reset `last` = 1, so requester 1 alone still wins, because it is the only one requesting).
